// File: rtl/alu_cmd_issue_if.sv
// Opcode/struct definitions shared with alu_8bit, plus the command-in /
// result-out handshake bundle used by alu_cmd_issue.

package alu_pkg;

  typedef enum logic [1:0] {
    ADD_OP = 2'd0,
    SUB_OP = 2'd1,
    AND_OP = 2'd2,
    OR_OP  = 2'd3
  } op_t;

  typedef struct packed {
    logic [7:0] A;
    logic [7:0] B;
    logic       cin;
    op_t        operation;
  } ALU_IO;

endpackage

interface alu_cmd_issue_if #(
  parameter int TAG_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_a;
  logic [7:0]        in_b;
  logic              in_cin;
  alu_pkg::op_t      in_op;

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_result;
  logic              out_carry;
  logic              out_zero;
  logic [TAG_W-1:0]  out_tag;

  // Master is the side that issues commands and consumes results.
  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_tag
  );

endinterface

// File: rtl/alu_cmd_issue.sv
// Command FIFO feeding a combinational alu_8bit; the ALU's answer for the
// head entry is captured into a registered, tagged, backpressured result slot.

module alu_cmd_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  alu_cmd_issue_if.slave               bus,
  output alu_pkg::ALU_IO               alu_io,
  input  logic [7:0]                   alu_result,
  input  logic                         alu_carry,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    alu_pkg::ALU_IO   cmd;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_result_q, out_result_d;
  logic             out_carry_q, out_carry_d;
  logic             out_zero_q, out_zero_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             not_empty;
  logic             push;
  logic             cap;
  entry_t           head;

  assign not_empty = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  // in_ready depends on occupancy alone, so no combinational path from the
  // consumer side back to the producer.
  assign bus.in_ready = (count_q != CNT_W'(DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign cap          = not_empty && (!out_valid_q || bus.out_ready);

  assign alu_io = not_empty ? head.cmd : '0;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    tag_d        = tag_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    out_tag_d    = out_tag_q;

    if (push) begin
      mem_d[wr_ptr_q].cmd.A         = bus.in_a;
      mem_d[wr_ptr_q].cmd.B         = bus.in_b;
      mem_d[wr_ptr_q].cmd.cin       = bus.in_cin;
      mem_d[wr_ptr_q].cmd.operation = bus.in_op;
      mem_d[wr_ptr_q].tag           = tag_q;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      tag_d    = tag_q + TAG_W'(1);
    end

    // The ALU answers for the head entry in the same cycle it is driven.
    if (cap) begin
      out_valid_d  = 1'b1;
      out_result_d = alu_result;
      out_carry_d  = alu_carry;
      out_zero_d   = (alu_result == 8'd0);
      out_tag_d    = head.tag;
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({push, cap})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= 8'd0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_tag_q    <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign count          = count_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_tag    = out_tag_q;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CNT_W'(DEPTH));

  a_stall_holds : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_tag_q)));

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue; a behavioural alu_8bit stand-in closes the
// combinational loop from alu_io back to alu_result/alu_carry.

module tb_alu_cmd_issue;

  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  ALU_IO       aluIo;
  logic [7:0]  aluResult;
  logic        aluCarry;
  logic [2:0]  count;

  int checks;
  int errors;

  alu_cmd_issue_if #(.TAG_W(8)) bus ();

  alu_cmd_issue #(
    .DEPTH (4),
    .TAG_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_io     (aluIo),
    .alu_result (aluResult),
    .alu_carry  (aluCarry),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for alu_8bit: purely combinational.
  always_comb begin
    logic [8:0] sum;
    sum = 9'd0;
    case (aluIo.operation)
      ADD_OP:  sum = 9'(aluIo.A) + 9'(aluIo.B) + 9'(aluIo.cin);
      SUB_OP:  sum = 9'(aluIo.A) - 9'(aluIo.B) - 9'(aluIo.cin);
      AND_OP:  sum = {1'b0, aluIo.A & aluIo.B};
      OR_OP:   sum = {1'b0, aluIo.A | aluIo.B};
      default: sum = 9'd0;
    endcase
    aluResult = sum[7:0];
    aluCarry  = sum[8];
  end

  task automatic driveCmd(input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input op_t op);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_op    = op;
  endtask

  // Present one command and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input op_t op);
    int waitCnt;
    waitCnt = 0;
    driveCmd(a, b, cin, op);
    while (!bus.in_ready && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout got in_ready=%0d expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic resetDut();
    @(posedge clk); #2;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'd0;
    bus.in_b      = 8'd0;
    bus.in_cin    = 1'b0;
    bus.in_op     = ADD_OP;
    bus.out_ready = 1'b0;
    #3;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0d expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0d expected 0", bus.out_valid); end
    checks++; if (bus.out_result !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_result got %0d expected 0", bus.out_result); end
    checks++; if (bus.out_tag !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_tag got %0d expected 0", bus.out_tag); end
    checks++; if (aluIo !== ALU_IO'(0)) begin errors++; $display("[TB] FAIL reset_alu_io got %h expected 0", aluIo); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    ALU_IO expIo;
    expIo = '{A: 8'd10, B: 8'd8, cin: 1'b0, operation: ADD_OP};
    bus.out_ready = 1'b1;
    driveCmd(8'd10, 8'd8, 1'b0, ADD_OP);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (aluIo !== expIo) begin errors++; $display("[TB] FAIL add_alu_io got %h expected %h", aluIo, expIo); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_early_valid got %0d expected 0", bus.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid got %0d expected 1", bus.out_valid); end
    checks++; if (bus.out_result !== 8'd18) begin errors++; $display("[TB] FAIL add_result got %0d expected 18", bus.out_result); end
    checks++; if (bus.out_carry !== 1'b0) begin errors++; $display("[TB] FAIL add_carry got %0d expected 0", bus.out_carry); end
    checks++; if (bus.out_zero !== 1'b0) begin errors++; $display("[TB] FAIL add_zero got %0d expected 0", bus.out_zero); end
    checks++; if (bus.out_tag !== 8'd0) begin errors++; $display("[TB] FAIL add_tag got %0d expected 0", bus.out_tag); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL add_count got %0d expected 0", count); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drain got %0d expected 0", bus.out_valid); end
  endtask

  task automatic test_overflow_add();
    applyStimulus(8'd255, 8'd1, 1'b0, ADD_OP);
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid got %0d expected 1", bus.out_valid); end
    checks++; if (bus.out_result !== 8'd0) begin errors++; $display("[TB] FAIL ovf_result got %0d expected 0", bus.out_result); end
    checks++; if (bus.out_carry !== 1'b1) begin errors++; $display("[TB] FAIL ovf_carry got %0d expected 1", bus.out_carry); end
    checks++; if (bus.out_zero !== 1'b1) begin errors++; $display("[TB] FAIL ovf_zero got %0d expected 1", bus.out_zero); end
    checks++; if (bus.out_tag !== 8'd1) begin errors++; $display("[TB] FAIL ovf_tag got %0d expected 1", bus.out_tag); end
  endtask

  task automatic test_backpressure();
    logic [7:0] expRes [5];
    expRes = '{8'd4, 8'd14, 8'd2, 8'd4, 8'd6};
    resetDut();
    bus.out_ready = 1'b0;
    applyStimulus(8'd4, 8'd7, 1'b0, AND_OP);
    applyStimulus(8'd8, 8'd6, 1'b0, OR_OP);
    applyStimulus(8'd1, 8'd1, 1'b0, ADD_OP);
    applyStimulus(8'd2, 8'd2, 1'b0, ADD_OP);
    applyStimulus(8'd3, 8'd3, 1'b0, ADD_OP);
    checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL bp_full_count got %0d expected 4", count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %0d expected 0", bus.in_ready); end
    // Offer a sixth command while full: it must be refused and the slot must hold.
    driveCmd(8'd99, 8'd1, 1'b0, ADD_OP);
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL bp_blocked_count got %0d expected 4", count); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid got %0d expected 1", bus.out_valid); end
    checks++; if (bus.out_result !== expRes[0]) begin errors++; $display("[TB] FAIL bp_result0 got %0d expected %0d", bus.out_result, expRes[0]); end
    checks++; if (bus.out_tag !== 8'd0) begin errors++; $display("[TB] FAIL bp_tag0 got %0d expected 0", bus.out_tag); end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid%0d got %0d expected 1", i, bus.out_valid); end
      checks++; if (bus.out_result !== expRes[i]) begin errors++; $display("[TB] FAIL bp_result%0d got %0d expected %0d", i, bus.out_result, expRes[i]); end
      checks++; if (bus.out_tag !== 8'(i)) begin errors++; $display("[TB] FAIL bp_tag%0d got %0d expected %0d", i, bus.out_tag, i); end
    end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain_valid got %0d expected 0", bus.out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL bp_drain_count got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      driveCmd(8'(i), 8'(i), 1'b0, ADD_OP);
      @(posedge clk); #1;
      if (i >= 1) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid%0d got %0d expected 1", i - 1, bus.out_valid); end
        checks++; if (bus.out_result !== 8'(2 * (i - 1))) begin errors++; $display("[TB] FAIL stream_result%0d got %0d expected %0d", i - 1, bus.out_result, 2 * (i - 1)); end
        checks++; if (count > 3'd1) begin errors++; $display("[TB] FAIL stream_count%0d got %0d expected <=1", i - 1, count); end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_result !== 8'd38) begin errors++; $display("[TB] FAIL stream_result19 got %0d expected 38", bus.out_result); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid19 got %0d expected 1", bus.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_tag_wrap();
    int gaps;
    gaps = 0;
    resetDut();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      driveCmd(8'd1, 8'd1, 1'b0, ADD_OP);
      @(posedge clk); #1;
      if (i >= 1 && bus.out_valid !== 1'b1) gaps++;
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_tag !== 8'd255) begin errors++; $display("[TB] FAIL wrap_tag255 got %0d expected 255", bus.out_tag); end
    @(posedge clk); #1;
    checks++; if (bus.out_tag !== 8'd0) begin errors++; $display("[TB] FAIL wrap_tag256 got %0d expected 0", bus.out_tag); end
    checks++; if (bus.out_result !== 8'd2) begin errors++; $display("[TB] FAIL wrap_result got %0d expected 2", bus.out_result); end
    checks++; if (gaps !== 0) begin errors++; $display("[TB] FAIL wrap_gaps got %0d expected 0", gaps); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    int spurious;
    spurious = 0;
    resetDut();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(8'd5, 8'd5, 1'b0, ADD_OP);
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL mid_pre_count got %0d expected 3", count); end
    checks++; if (bus.out_result !== 8'd10) begin errors++; $display("[TB] FAIL mid_pre_result got %0d expected 10", bus.out_result); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL mid_count got %0d expected 0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %0d expected 0", bus.out_valid); end
    checks++; if (bus.out_result !== 8'd0) begin errors++; $display("[TB] FAIL mid_result got %0d expected 0", bus.out_result); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready got %0d expected 1", bus.in_ready); end
    checks++; if (aluIo !== ALU_IO'(0)) begin errors++; $display("[TB] FAIL mid_alu_io got %h expected 0", aluIo); end
    @(posedge clk); #2;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("[TB] FAIL mid_spurious got %0d expected 0", spurious); end
    applyStimulus(8'd9, 8'd3, 1'b0, ADD_OP);
    @(posedge clk); #1;
    checks++; if (bus.out_result !== 8'd12) begin errors++; $display("[TB] FAIL mid_new_result got %0d expected 12", bus.out_result); end
    checks++; if (bus.out_tag !== 8'd0) begin errors++; $display("[TB] FAIL mid_new_tag got %0d expected 0", bus.out_tag); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_add();
    test_overflow_add();
    test_backpressure();
    test_back_to_back();
    test_tag_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
# alu_cmd_issue

Command buffer and issue stage that sits directly upstream of `alu_8bit`. It accepts ALU commands over a valid/ready interface into a small FIFO and drives the head command onto the ALU's `ALU_IO` struct input. It captures the ALU's combinational `result`/`carry_out` into a registered output slot with status flags and a sequence tag. Downstream consumers see one registered result per accepted command, in order, with backpressure.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TAG_W`, 8: sequence tag width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  FIFO can accept; equals `count < DEPTH`.
- `in_a`, `in_b`  in  8  operands.
- `in_cin`  in  1  carry-in.
- `in_op`  in  `alu_pkg` opcode type  ADD_OP/SUB_OP/AND_OP/OR_OP.
- `alu_io`  out  `ALU_IO`  {A, B, cin, operation} to `alu_8bit`; equals FIFO head, all-zero when empty.
- `alu_result`  in  8  `alu_8bit` result.
- `alu_carry`  in  1  `alu_8bit` carry_out.
- `out_valid`  out  1  registered result available.
- `out_ready`  in  1  consumer takes result.
- `out_result`  out  8  captured result.
- `out_carry`  out  1  captured carry_out.
- `out_zero`  out  1  `out_result == 0`, registered with result.
- `out_tag`  out  `TAG_W`  sequence number of the command that produced this result.
- `count`  out  `$clog2(DEPTH+1)`  FIFO occupancy.

## Operation
- Push: `in_valid && in_ready` at an edge writes {a, b, cin, op, tag} at `wr_ptr`; `wr_ptr` increments mod DEPTH; tag counter increments, wrapping 2^TAG_W−1 → 0. First command after reset gets tag 0.
- Head drive: while `count > 0`, `alu_io` = head entry fields; `alu_8bit` is purely combinational, so `alu_result`/`alu_carry` are valid in the same cycle.
- Capture condition `cap = (count > 0) && (!out_valid || out_ready)`. On `cap`: `out_result`, `out_carry`, `out_zero`, `out_tag` load from ALU/head; `out_valid` ← 1; head pops (`rd_ptr` +1 mod DEPTH).
- `out_valid && out_ready && !cap` → `out_valid` ← 0. Output fields hold their value until the next capture.
- Simultaneous push and pop: `count` unchanged, both pointers advance. Push while full is blocked by `in_ready = 0`; there is no pass-through when full, even if a pop occurs in the same cycle.
- Output registers and flags hold while `out_valid && !out_ready` (stall). The FIFO keeps accepting until full.
- Carry is passed through unmodified for every op; `out_zero` is computed for every op.
- Results leave strictly in acceptance order; no command is dropped or duplicated.

## Timing
- Reset (async assert, sync-to-clock deassert handled externally): `count` = 0, pointers = 0, tag counter = 0, `out_valid` = 0, `out_result` = 0, `out_carry` = 0, `out_zero` = 0, `out_tag` = 0, `alu_io` = 0, `in_ready` = 1.
- Reset mid-operation discards FIFO contents and any pending output immediately, with no further `out_valid`.
- Latency: a command accepted at edge N into an empty FIFO, with the output slot free, is driven on `alu_io` during cycle N..N+1. It is captured at edge N+1 and `out_valid` is high from N+1.
- Throughput is 1 result/cycle with `out_ready` held high and a continuous `in_valid`.
- `in_ready` is combinational from `count` only, never from `in_valid` or `out_ready`.

## Test plan
- Single ADD: a=10, b=8, cin=0, ADD_OP → one cycle after accept, out_result=18, carry=0, zero=0, tag=0.
- Overflow ADD: a=255, b=1, cin=0 → out_result=0, carry=1, zero=1.
- Backpressure: `out_ready`=0, push 5 commands (AND 4&7, OR 8|6, ADD 1+1, ADD 2+2, ADD 3+3). The first is captured, the FIFO fills to 4, and `in_ready` drops after the 5th accept. Release `out_ready` → results 4, 14, 2, 4, 6 are produced in order with tags 0..4.
- Streaming: 20 back-to-back ADD i+i with `out_ready`=1 → 20 results on consecutive cycles, `count` ≤1, no gaps after the first.
- Tag wrap: 257 commands → the 257th result has tag 0.
- Reset mid-stream: assert `rst_n`=0 with `count`=3 and `out_valid`=1 → all outputs go to reset values asynchronously. After release, a new ADD 9+3 returns 12 with tag 0.
